// File: rtl/calc_scheduler.sv
// Two-requester arithmetic command scheduler: arbitrates one command at a time,
// executes add/sub in one cycle or multiply by 16-step shift-add, holds result until taken.
module calc_scheduler #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [7:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [7:0]  req1_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_id,
  output logic        out_err,
  output logic        busy
);

  localparam int unsigned DW   = 16;
  localparam int unsigned OPW  = 8;
  localparam int unsigned CNTW = 5;

  localparam logic [OPW-1:0]  OP_MUL   = 8'h2A;
  localparam logic [OPW-1:0]  OP_ADD   = 8'h2B;
  localparam logic [OPW-1:0]  OP_SUB   = 8'h2D;
  localparam logic [CNTW-1:0] MUL_LAST = CNTW'(15);
  localparam logic [DW-1:0]   ERR_VAL  = '1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic            idle_c;
  logic            grant_c;
  logic            hs_c;
  logic [DW-1:0]   sel_x_c, sel_y_c;
  logic [OPW-1:0]  sel_op_c;

  // Arbitration: ties go to the requester not granted last (round-robin) or to requester 0
  always_comb begin
    grant_c = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_c = RR_ENABLE ? ~last_q : 1'b0;
    end
  end

  assign idle_c     = (state_q == IDLE) && rst_n;
  assign hs_c       = idle_c && (req0_valid || req1_valid);
  assign req0_ready = idle_c && req0_valid && !grant_c;
  assign req1_ready = idle_c && req1_valid && grant_c;

  assign sel_x_c  = grant_c ? req1_x  : req0_x;
  assign sel_y_c  = grant_c ? req1_y  : req0_y;
  assign sel_op_c = grant_c ? req1_op : req0_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath; a_q/b_q double as operands and multiplicand/multiplier
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (hs_c) begin
          last_d  = grant_c;
          id_d    = grant_c;
          op_d    = sel_op_c;
          a_d     = sel_x_c;
          b_d     = sel_y_c;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (sel_op_c == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        state_d = DONE;
        err_d   = 1'b0;
        if (op_q == OP_ADD) begin
          data_d = a_q + b_q;
        end else if (op_q == OP_SUB) begin
          data_d = a_q - b_q;
        end else begin
          data_d = ERR_VAL;
          err_d  = 1'b1;
        end
      end
      MUL: begin
        if (b_q[0]) begin
          acc_d = acc_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == MUL_LAST) begin
          state_d = DONE;
          data_d  = acc_d;
          err_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_scheduler.sv
// Bench for calc_scheduler: directed scenarios plus randomized commands against
// an arithmetic/arbitration reference model; a second instance covers fixed priority.
module tb_calc_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic [7:0]  req0_op = '0, req1_op = '0;

  logic        req0_ready, req1_ready, out_valid, out_id, out_err, busy;
  logic [15:0] out_data;
  logic        f_req0_ready, f_req1_ready, f_out_valid, f_out_id, f_out_err, f_busy;
  logic [15:0] f_out_data;

  int n_pass = 0;
  int n_chk  = 0;
  int m_last = 1;

  always #5 clk = ~clk;

  calc_scheduler #(.RR_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_err(out_err), .busy(busy)
  );

  calc_scheduler #(.RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data), .out_id(f_out_id),
    .out_err(f_out_err), .busy(f_busy)
  );

  // Reference result {err, data} from plain 32-bit arithmetic
  function automatic logic [16:0] model_alu(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] r;
    case (op)
      8'h2A: r = 32'(x) * 32'(y);
      8'h2B: r = 32'(x) + 32'(y);
      8'h2D: r = 32'(x) - 32'(y);
      default: return {1'b1, 16'hFFFF};
    endcase
    return {1'b0, r[15:0]};
  endfunction

  function automatic int model_lat(input logic [7:0] op);
    return (op == 8'h2A) ? 17 : 2;
  endfunction

  function automatic int model_grant(input logic v0, input logic v1, input bit rr, input int last);
    if (v0 && v1) return rr ? ((last == 0) ? 1 : 0) : 0;
    return v1 ? 1 : 0;
  endfunction

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 4))
      0: return 8'h2A;
      1: return 8'h2B;
      2: return 8'h2D;
      3: return 8'($urandom);
      default: return 8'($urandom) | 8'h80;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    req0_x = 16'($urandom); req0_y = 16'($urandom); req0_op = 8'($urandom);
    req1_x = 16'($urandom); req1_y = 16'($urandom); req1_op = 8'($urandom);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    m_last = 1;
  endtask

  // Waits (bounded) for a ready; g = requester index, 2 if both, -1 on timeout
  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req0_ready && req1_ready) g = 2;
      else if (req0_ready) g = 0;
      else if (req1_ready) g = 1;
      if (g != -1) break;
      tick();
    end
  endtask

  // Called right after the handshake edge; lat is the cycle index N+lat where out_valid first appears
  task automatic wait_result(output logic [15:0] d, output logic id, output logic err,
                             output int lat, output logic busy_all);
    int k = 0;
    busy_all = busy;
    while (!out_valid && k < 40) begin
      tick();
      k++;
      busy_all &= busy;
    end
    lat = out_valid ? k + 1 : -1;
    d = out_data; id = out_id; err = out_err;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic issue(input int id, input logic [15:0] x, input logic [15:0] y,
                       input logic [7:0] op, output int g);
    scramble();
    if (id == 0) begin req0_x = x; req0_y = y; req0_op = op; end
    else         begin req1_x = x; req1_y = y; req1_op = op; end
    req0_valid = (id == 0);
    req1_valid = (id == 1);
    wait_grant(g);
    tick();
    m_last = id;
    req0_valid = 1'b0; req1_valid = 1'b0;
    scramble();
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== 16'h0) $display("FAIL rst_out_data: got %h want 0000", out_data); else n_pass++;
    n_chk++; if ({out_id, out_err, busy} !== 3'b000) $display("FAIL rst_id_err_busy: got %b want 000", {out_id, out_err, busy}); else n_pass++;
    n_chk++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    m_last = 1;
    #1;
    n_chk++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rst_first_grant: got %b want 10", {req0_ready, req1_ready}); else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    n_chk++; if (busy !== 1'b0) $display("FAIL dropped_valid_accepted: busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_add();
    int g, lat; logic [15:0] d; logic id, err, ba;
    issue(0, 16'h0005, 16'h0003, 8'h2B, g);
    n_chk++; if (g !== 0) $display("FAIL add_grant: got %0d want 0", g); else n_pass++;
    wait_result(d, id, err, lat, ba);
    n_chk++; if (d !== 16'h0008) $display("FAIL add_data: got %h want 0008", d); else n_pass++;
    n_chk++; if ({id, err} !== 2'b00) $display("FAIL add_id_err: got %b want 00", {id, err}); else n_pass++;
    n_chk++; if (lat !== 2) $display("FAIL add_latency: got %0d want 2", lat); else n_pass++;
    release_result();
  endtask

  task automatic test_mul();
    int g, lat; logic [15:0] d; logic id, err, ba;
    issue(1, 16'hFFFE, 16'h0003, 8'h2A, g);
    n_chk++; if (g !== 1) $display("FAIL mul_grant: got %0d want 1", g); else n_pass++;
    wait_result(d, id, err, lat, ba);
    n_chk++; if (d !== 16'hFFFA) $display("FAIL mul_data: got %h want FFFA", d); else n_pass++;
    n_chk++; if ({id, err} !== 2'b10) $display("FAIL mul_id_err: got %b want 10", {id, err}); else n_pass++;
    n_chk++; if (lat !== 17) $display("FAIL mul_latency: got %0d want 17", lat); else n_pass++;
    n_chk++; if (ba !== 1'b1) $display("FAIL mul_busy: got %b want 1", ba); else n_pass++;
    release_result();
  endtask

  task automatic test_sub_err();
    logic [7:0] ops [3] = '{8'h2D, 8'h2F, 8'hAA};
    logic       errs[3] = '{1'b0, 1'b1, 1'b1};
    int g, lat; logic [15:0] d; logic id, err, ba;
    for (int i = 0; i < 3; i++) begin
      issue(0, 16'h0000, 16'h0001, ops[i], g);
      wait_result(d, id, err, lat, ba);
      n_chk++; if (d !== 16'hFFFF) $display("FAIL sub_err_data op=%h: got %h want FFFF", ops[i], d); else n_pass++;
      n_chk++; if (err !== errs[i]) $display("FAIL sub_err_flag op=%h: got %b want %b", ops[i], err, errs[i]); else n_pass++;
      release_result();
    end
  endtask

  task automatic test_random();
    logic [15:0] xs[2], ys[2]; logic [7:0] ops[2];
    logic v0, v1; int eg, g, lat; logic [15:0] d; logic id, err, ba; logic [16:0] exp;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) tick();
      do begin v0 = 1'($urandom); v1 = 1'($urandom); end while (!v0 && !v1);
      for (int r = 0; r < 2; r++) begin
        xs[r] = 16'($urandom); ys[r] = 16'($urandom); ops[r] = rand_op();
      end
      req0_x = xs[0]; req0_y = ys[0]; req0_op = ops[0];
      req1_x = xs[1]; req1_y = ys[1]; req1_op = ops[1];
      req0_valid = v0; req1_valid = v1;
      eg = model_grant(v0, v1, 1'b1, m_last);
      wait_grant(g);
      n_chk++; if (g !== eg) $display("FAIL rnd_grant it=%0d: got %0d want %0d", it, g, eg); else n_pass++;
      tick();
      m_last = eg;
      req0_valid = 1'b0; req1_valid = 1'b0;
      scramble();
      out_ready = 1'($urandom);
      exp = model_alu(ops[eg], xs[eg], ys[eg]);
      wait_result(d, id, err, lat, ba);
      n_chk++; if (d !== exp[15:0]) $display("FAIL rnd_data it=%0d op=%h: got %h want %h", it, ops[eg], d, exp[15:0]); else n_pass++;
      n_chk++; if (err !== exp[16]) $display("FAIL rnd_err it=%0d op=%h: got %b want %b", it, ops[eg], err, exp[16]); else n_pass++;
      n_chk++; if (id !== 1'(eg)) $display("FAIL rnd_id it=%0d: got %b want %0d", it, id, eg); else n_pass++;
      n_chk++; if (lat !== model_lat(ops[eg])) $display("FAIL rnd_latency it=%0d: got %0d want %0d", it, lat, model_lat(ops[eg])); else n_pass++;
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int qrr[$], qfp[$]; int both = 0; int cyc = 0;
    do_reset();
    req0_x = 16'h0001; req0_y = 16'h0002; req0_op = 8'h2B;
    req1_x = 16'h0003; req1_y = 16'h0004; req1_op = 8'h2B;
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    while ((qrr.size() < 4 || qfp.size() < 4) && cyc < 200) begin
      #1;
      if ((req0_ready && req1_ready) || (f_req0_ready && f_req1_ready)) both++;
      if (req0_ready && qrr.size() < 4) qrr.push_back(0);
      if (req1_ready && qrr.size() < 4) qrr.push_back(1);
      if (f_req0_ready && qfp.size() < 4) qfp.push_back(0);
      if (f_req1_ready && qfp.size() < 4) qfp.push_back(1);
      tick();
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_chk++; if (both !== 0) $display("FAIL b2b_both_ready: got %0d cycles want 0", both); else n_pass++;
    n_chk++; if (qrr.size() != 4 || qrr[0] != 0 || qrr[1] != 1 || qrr[2] != 0 || qrr[3] != 1)
      $display("FAIL b2b_rr_order: got %p want 0,1,0,1", qrr); else n_pass++;
    n_chk++; if (qfp.size() != 4 || qfp[0] != 0 || qfp[1] != 0 || qfp[2] != 0 || qfp[3] != 0)
      $display("FAIL b2b_fixed_order: got %p want 0,0,0,0", qfp); else n_pass++;
    repeat (4) tick();
    out_ready = 1'b0;
    m_last = 1;
  endtask

  task automatic test_stall();
    int g, lat, eg; logic [15:0] d, d2; logic id, err, ba; logic [16:0] exp;
    logic [15:0] x1, y1; int unstable = 0, rdy = 0;
    issue(0, 16'h1234, 16'h0F0F, 8'h2B, g);
    wait_result(d, id, err, lat, ba);
    n_chk++; if (d !== 16'h2143) $display("FAIL stall_data: got %h want 2143", d); else n_pass++;
    x1 = 16'($urandom); y1 = 16'($urandom);
    req1_x = x1; req1_y = y1; req1_op = 8'h2D;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (10) begin
      #1;
      if (req0_ready || req1_ready) rdy++;
      tick();
      if (out_valid !== 1'b1 || out_data !== d || out_id !== id || out_err !== err) unstable++;
    end
    n_chk++; if (unstable !== 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); else n_pass++;
    n_chk++; if (rdy !== 0) $display("FAIL stall_ready: got %0d ready cycles want 0", rdy); else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    eg = model_grant(1'b1, 1'b1, 1'b1, m_last);
    n_chk++; if (busy !== 1'b0) $display("FAIL stall_no_hs_on_exit: busy got %b want 0", busy); else n_pass++;
    n_chk++; if (req1_ready !== 1'(eg) || req0_ready !== 1'(1 - eg)) $display("FAIL stall_next_grant: got %b%b want grant %0d", req0_ready, req1_ready, eg); else n_pass++;
    tick();
    m_last = eg;
    req0_valid = 1'b0; req1_valid = 1'b0;
    scramble();
    n_chk++; if (busy !== 1'b1) $display("FAIL stall_next_hs: busy got %b want 1", busy); else n_pass++;
    exp = model_alu(8'h2D, x1, y1);
    wait_result(d2, id, err, lat, ba);
    n_chk++; if ({id, err, d2} !== {1'b1, exp}) $display("FAIL stall_next_result: got %b %b %h want 1 %b %h", id, err, d2, exp[16], exp[15:0]); else n_pass++;
    release_result();
  endtask

  task automatic test_reset_mul();
    int g, lat, seen = 0; logic [15:0] d; logic id, err, ba;
    issue(0, 16'h00F3, 16'h0101, 8'h2A, g);
    repeat (7) tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({out_valid, busy, out_id, out_err, req0_ready, req1_ready} !== 6'b0) $display("FAIL midrst_ctrl: got %b want 000000", {out_valid, busy, out_id, out_err, req0_ready, req1_ready}); else n_pass++;
    n_chk++; if (out_data !== 16'h0) $display("FAIL midrst_data: got %h want 0000", out_data); else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    m_last = 1;
    repeat (30) begin
      tick();
      if (out_valid || busy) seen++;
    end
    n_chk++; if (seen !== 0) $display("FAIL midrst_ghost_result: got %0d active cycles want 0", seen); else n_pass++;
    req0_x = 16'h0002; req0_y = 16'h0003; req0_op = 8'h2A;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grant(g);
    n_chk++; if (g !== model_grant(1'b1, 1'b1, 1'b1, m_last)) $display("FAIL midrst_first_grant: got %0d want 0", g); else n_pass++;
    tick();
    m_last = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result(d, id, err, lat, ba);
    n_chk++; if (d !== 16'h0006) $display("FAIL midrst_after_data: got %h want 0006", d); else n_pass++;
    release_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_sub_err();
    test_random();
    test_back_to_back();
    test_stall();
    test_reset_mul();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_scheduler.md
CALC_SCHEDULER -- requirements
Module: calc_scheduler

Interface
REQ-001 SHALL have parameter RR_ENABLE, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with requester 0 winning.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester has a command pending.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1 bit each: command accepted this cycle when valid and ready are both 1.
REQ-006 SHALL have ports req0_x, req0_y / req1_x, req1_y, input, 16 bits each: operands.
REQ-007 SHALL have ports req0_op / req1_op, input, 8 bits each: ASCII opcode ('*'=0x2A, '+'=0x2B, '-'=0x2D).
REQ-008 SHALL have port out_valid, output, 1 bit: result available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-010 SHALL have port out_data, output, 16 bits: result.
REQ-011 SHALL have port out_id, output, 1 bit: index of the requester that issued the result.
REQ-012 SHALL have port out_err, output, 1 bit: opcode was unsupported.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, MUL and DONE, with exactly one command in flight at any time.
REQ-015 SHALL drive reqN_ready only in IDLE, only for the granted requester, and never to both requesters in the same cycle.
REQ-016 SHALL arbitrate in IDLE as follows: one valid requester -> grant it; both valid with RR_ENABLE=1 -> grant the requester not granted last; both valid with RR_ENABLE=0 -> grant requester 0.
REQ-017 SHALL update the last-grant pointer only on an accepted handshake; idle cycles leave it unchanged.
REQ-018 SHALL capture x, y, op and the requester id into internal registers at the handshake; later input changes have no effect on the command in flight.
REQ-019 SHALL move from IDLE to EXEC for op 0x2B, 0x2D or an unsupported op, and to MUL for op 0x2A.
REQ-020 SHALL decode op by 8-bit equality only; any op with bit 7 set is unsupported.
REQ-021 SHALL, in EXEC, register the result in one cycle and move to DONE: '+' -> (x+y) mod 2^16; '-' -> (x-y) mod 2^16; unsupported -> 0xFFFF with out_err=1.
REQ-022 SHALL compute '*' as the low 16 bits of the product, which is identical for signed and unsigned operands.
REQ-023 SHALL perform '*' as an iterative shift-add over exactly 16 MUL cycles using a 5-bit counter; each cycle adds the multiplicand into the accumulator when the multiplier LSB is 1, then shifts the multiplicand left and the multiplier right, all modulo 2^16.
REQ-024 SHALL move from MUL to DONE after the 16th MUL cycle.
REQ-025 SHALL meet this latency, with the handshake at edge N: add/sub/unsupported -> out_valid high from cycle N+2; multiply -> out_valid high from cycle N+17.
REQ-026 SHALL hold out_valid, out_data, out_id and out_err stable in DONE until out_ready=1; on that edge the FSM returns to IDLE.
REQ-027 SHALL NOT accept a new request in the same cycle as a DONE->IDLE transition; the earliest next handshake is the following cycle.
REQ-028 SHALL drive out_valid=0 outside DONE, and out_err=0 for supported ops.
REQ-029 SHALL ignore out_ready outside DONE.
REQ-030 SHALL ignore a requester dropping valid before it is granted; no command is accepted for it.

Reset
REQ-031 SHALL, on rst_n=0, immediately set state=IDLE, out_valid=0, out_data=0, out_id=0, out_err=0, busy=0, reqN_ready=0, multiply counter=0, accumulator=0, and last-grant=1 so requester 0 wins first.
REQ-032 SHALL abandon any command in flight when reset is asserted mid-EXEC, mid-MUL or in DONE, and produce no result for it after release.
REQ-033 SHALL treat the first rising clk edge with rst_n=1 as a normal IDLE cycle.

Verification
REQ-034 SHALL pass this scenario: req0 x=0x0005, y=0x0003, op=0x2B -> out_data=0x0008, out_id=0, out_err=0, with out_valid two cycles after the handshake.
REQ-035 SHALL pass this scenario: req1 x=0xFFFE, y=0x0003, op=0x2A -> out_data=0xFFFA, out_valid at N+17, busy high throughout.
REQ-036 SHALL pass this scenario: req0 x=0x0000, y=0x0001, op=0x2D -> 0xFFFF with out_err=0; then op=0x2F -> 0xFFFF with out_err=1; then op=0xAA -> 0xFFFF with out_err=1.
REQ-037 SHALL pass this scenario: both requesters continuously valid, RR_ENABLE=1 -> grants alternate 0,1,0,1; with RR_ENABLE=0 -> grants are always 0.
REQ-038 SHALL pass this scenario: out_ready held 0 for 10 cycles in DONE -> outputs stable and no reqN_ready; then out_ready=1 -> IDLE, next handshake one cycle later.
REQ-039 SHALL pass this scenario: rst_n pulsed low at MUL cycle 8 -> outputs reset asynchronously, no result emitted after release, and requester 0 granted first.
